buff_uart_arbiter: RTL and testbench

Round-robin arbiter that shares the single register port of a buffered UART (address, write data, read/write enables, read data) among `n_requesters` independent bus masters. Each requester issues one read or write per handshake. The arbiter serialises the requests, drives exactly one UART enable pulse per granted transfer, and returns completion (plus read data) to the winner. It sits between the system-side masters and the buffered UART's register port.

---
 rtl/buff_uart_arbiter_if.sv | 60 ++++++
 rtl/buff_uart_arbiter.sv | 217 +++++++++++++++++++++
 tb/tb_buff_uart_arbiter.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/buff_uart_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : buff_uart_arbiter_if
// Description : Requester-side bus of the buffered-UART register-port arbiter.
//               Carries the packed per-requester request operands together
//               with the one-hot grant/done pulses and the shared read data.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Signals:
//   req         N            per-requester request level
//   req_write   N            1 = write, 0 = read
//   req_address N*ADDR_W     requester i at [i*ADDRESS_WIDTH +: ADDRESS_WIDTH]
//   req_data    N*WIDTH      requester i at [i*WIDTH +: WIDTH]
//   lock        N            keep the grant for back-to-back transfers
//   grant       N            one-hot pulse, request accepted
//   done        N            one-hot pulse, transfer completed
//   rd_data     WIDTH        read result, valid with done of a read
// Modports:
//   master : driven by the requesters (system side)
//   slave  : seen by the arbiter
// ============================================================================
interface buff_uart_arbiter_if #(
  parameter int N_REQUESTERS  = 2,
  parameter int WIDTH         = 8,
  parameter int ADDRESS_WIDTH = 4
);

  logic [N_REQUESTERS-1:0]               req;
  logic [N_REQUESTERS-1:0]               req_write;
  logic [N_REQUESTERS*ADDRESS_WIDTH-1:0] req_address;
  logic [N_REQUESTERS*WIDTH-1:0]         req_data;
  logic [N_REQUESTERS-1:0]               lock;
  logic [N_REQUESTERS-1:0]               grant;
  logic [N_REQUESTERS-1:0]               done;
  logic [WIDTH-1:0]                      rd_data;

  modport master (
    output req,
    output req_write,
    output req_address,
    output req_data,
    output lock,
    input  grant,
    input  done,
    input  rd_data
  );

  modport slave (
    input  req,
    input  req_write,
    input  req_address,
    input  req_data,
    input  lock,
    output grant,
    output done,
    output rd_data
  );

endinterface
`default_nettype wire

// File: rtl/buff_uart_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : buff_uart_arbiter
// Description : Round-robin arbiter sharing the single register port of a
//               buffered UART among N_REQUESTERS bus masters. One transfer is
//               granted, issued to the UART as exactly one enable pulse and
//               completed with a one-hot done pulse (plus read data).
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Configuration macro:
//   BUFF_UART_ARB_LOCK_EN  defined   : lock[winner] & req[winner] in CAPTURE
//                                       keeps the grant with the same winner.
//                          undefined : lock is ignored, pure round-robin.
// ----------------------------------------------------------------------------
// Ports:
//   clock_i                in   sole clock, rising edge
//   reset_i                in   synchronous active-high reset
//   bus                    slave modport of buff_uart_arbiter_if
//   uart_active_address_o  out  UART active_address
//   uart_data_in_o         out  UART data_in
//   uart_write_enable_o    out  UART write_enable (one-cycle pulse)
//   uart_read_enable_o     out  UART read_enable (one-cycle pulse)
//   uart_data_out_i        in   UART data_out, valid one cycle after read
// ----------------------------------------------------------------------------
// Cycle timeline of one transfer (cycle numbers are output-visible cycles):
//   t   : state IDLE, grant[winner] high
//   t+1 : state ISSUE, one UART enable high with the latched operands
//   t+2 : state CAPTURE, uart_data_out sampled at the end of the cycle
//   t+3 : state IDLE, done[winner] (and rd_data) high; a new grant may be
//         presented in this same cycle.
// ============================================================================
module buff_uart_arbiter #(
  parameter int N_REQUESTERS  = 2,
  parameter int WIDTH         = 8,
  parameter int ADDRESS_WIDTH = 4
) (
  input  logic                     clock_i,
  input  logic                     reset_i,
  buff_uart_arbiter_if.slave       bus,
  output logic [ADDRESS_WIDTH-1:0] uart_active_address_o,
  output logic [WIDTH-1:0]         uart_data_in_o,
  output logic                     uart_write_enable_o,
  output logic                     uart_read_enable_o,
  input  logic [WIDTH-1:0]         uart_data_out_i
);

  localparam int IDX_W = (N_REQUESTERS > 1) ? $clog2(N_REQUESTERS) : 1;

  localparam logic [N_REQUESTERS-1:0] ONE_HOT_LSB =
    {{(N_REQUESTERS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_CAPTURE = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  state_t                    state_q;
  logic [IDX_W-1:0]          ptr_q;
  logic [IDX_W-1:0]          win_q;
  logic                      wr_q;
  logic [ADDRESS_WIDTH-1:0]  addr_q;
  logic [WIDTH-1:0]          data_q;
  logic [N_REQUESTERS-1:0]   grant_q;
  logic [N_REQUESTERS-1:0]   done_q;
  logic [WIDTH-1:0]          rd_data_q;
  logic [ADDRESS_WIDTH-1:0]  uart_addr_q;
  logic [WIDTH-1:0]          uart_din_q;
  logic                      uart_we_q;
  logic                      uart_re_q;

  // --------------------------------------------------------------------------
  // Unpack the per-requester operand buses
  // --------------------------------------------------------------------------
  logic [ADDRESS_WIDTH-1:0]  w_addr_arr [N_REQUESTERS];
  logic [WIDTH-1:0]          w_data_arr [N_REQUESTERS];

  for (genvar gi = 0; gi < N_REQUESTERS; gi++) begin : g_unpack
    assign w_addr_arr[gi] = bus.req_address[gi*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    assign w_data_arr[gi] = bus.req_data[gi*WIDTH +: WIDTH];
  end

  // --------------------------------------------------------------------------
  // Pointer that CAPTURE will leave behind: normally winner+1 (mod N), or the
  // winner itself while a lock is being held.
  // --------------------------------------------------------------------------
  logic             w_hold;
  logic [IDX_W-1:0] w_win_inc;
  logic [IDX_W-1:0] w_cap_ptr;

`ifdef BUFF_UART_ARB_LOCK_EN
  assign w_hold = bus.lock[win_q] & bus.req[win_q];
`else
  logic unused_lock;
  assign unused_lock = ^bus.lock;
  assign w_hold      = 1'b0;
`endif

  assign w_win_inc = (win_q == IDX_W'(N_REQUESTERS - 1)) ? '0 : win_q + 1'b1;
  assign w_cap_ptr = w_hold ? win_q : w_win_inc;

  // --------------------------------------------------------------------------
  // Round-robin pick. The arbitration done on the CAPTURE edge must already
  // see the updated pointer, so the search base is chosen by state.
  // --------------------------------------------------------------------------
  logic [IDX_W-1:0]        w_base;
  logic [N_REQUESTERS-1:0] w_req_rot;
  logic                    w_found;
  logic [IDX_W-1:0]        w_pick;

  assign w_base    = (state_q == S_CAPTURE) ? w_cap_ptr : ptr_q;
  // Rotate req so that bit 0 is the requester at the search base.
  assign w_req_rot = N_REQUESTERS'({bus.req, bus.req} >> w_base);

  always_comb begin
    int p;
    w_found = 1'b0;
    w_pick  = '0;
    p       = 0;
    for (int j = 0; j < N_REQUESTERS; j++) begin
      if (!w_found && w_req_rot[j]) begin
        w_found = 1'b1;
        p       = int'(w_base) + j;
        if (p >= N_REQUESTERS) begin
          p = p - N_REQUESTERS;
        end
        w_pick = p[IDX_W-1:0];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Controller. grant_q doubles as the "granted, issue next" marker in IDLE:
  // it is high for exactly the one IDLE cycle following an accepted request.
  // --------------------------------------------------------------------------
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      win_q       <= '0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      grant_q     <= '0;
      done_q      <= '0;
      rd_data_q   <= '0;
      uart_addr_q <= '0;
      uart_din_q  <= '0;
      uart_we_q   <= 1'b0;
      uart_re_q   <= 1'b0;
    end else begin
      grant_q   <= '0;
      done_q    <= '0;
      uart_we_q <= 1'b0;
      uart_re_q <= 1'b0;

      unique case (state_q)
        S_IDLE: begin
          if (|grant_q) begin
            state_q     <= S_ISSUE;
            uart_addr_q <= addr_q;
            uart_din_q  <= data_q;
            uart_we_q   <= wr_q;
            uart_re_q   <= ~wr_q;
          end else if (w_found) begin
            grant_q <= ONE_HOT_LSB << w_pick;
            win_q   <= w_pick;
            wr_q    <= bus.req_write[w_pick];
            addr_q  <= w_addr_arr[w_pick];
            data_q  <= w_data_arr[w_pick];
          end
        end

        S_ISSUE: begin
          state_q <= S_CAPTURE;
        end

        S_CAPTURE: begin
          state_q <= S_IDLE;
          done_q  <= ONE_HOT_LSB << win_q;
          ptr_q   <= w_cap_ptr;
          if (!wr_q) begin
            rd_data_q <= uart_data_out_i;
          end
          // Next arbitration overlaps this completion.
          if (w_found) begin
            grant_q <= ONE_HOT_LSB << w_pick;
            win_q   <= w_pick;
            wr_q    <= bus.req_write[w_pick];
            addr_q  <= w_addr_arr[w_pick];
            data_q  <= w_data_arr[w_pick];
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.grant             = grant_q;
  assign bus.done              = done_q;
  assign bus.rd_data           = rd_data_q;
  assign uart_active_address_o = uart_addr_q;
  assign uart_data_in_o        = uart_din_q;
  assign uart_write_enable_o   = uart_we_q;
  assign uart_read_enable_o    = uart_re_q;

endmodule
`default_nettype wire

// File: tb/tb_buff_uart_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_buff_uart_arbiter
// Description : Self-checking bench for buff_uart_arbiter (N=2, 8-bit data,
//               4-bit address) with a small UART register-file stub, a
//               transaction-level reference model and directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_buff_uart_arbiter;

  localparam int N  = 2;
  localparam int W  = 8;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  buff_uart_arbiter_if #(.N_REQUESTERS(N), .WIDTH(W), .ADDRESS_WIDTH(AW)) bus ();

  logic [AW-1:0] uaddr;
  logic [W-1:0]  udin;
  logic [W-1:0]  udout;
  logic          uwe;
  logic          ure;

  buff_uart_arbiter #(.N_REQUESTERS(N), .WIDTH(W), .ADDRESS_WIDTH(AW)) dut (
    .clock_i               (clk),
    .reset_i               (rst),
    .bus                   (bus),
    .uart_active_address_o (uaddr),
    .uart_data_in_o        (udin),
    .uart_write_enable_o   (uwe),
    .uart_read_enable_o    (ure),
    .uart_data_out_i       (udout)
  );

  // UART register-file stub: read data appears one cycle after read_enable.
  // Contents are re-seeded on reset to 0x37 + address (so address 5 = 0x3C).
  logic [W-1:0] umem [16];
  always @(posedge clk) begin
    if (rst) begin
      udout <= '0;
      for (int i = 0; i < 16; i++) umem[i] <= W'(8'h37 + i);
    end else begin
      if (ure) udout <= umem[uaddr];
      if (uwe) umem[uaddr] <= udin;
    end
  end

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: a transfer is a record with an age counted in cycles from
  // its grant. Outputs for the next cycle are derived from the age and from
  // the round-robin rule applied to the sampled requests.
  // --------------------------------------------------------------------------
  logic [N-1:0]  exp_grant, exp_done;
  logic          exp_we, exp_re;
  logic [AW-1:0] exp_ua;
  logic [W-1:0]  exp_ud, exp_rd;
  logic [W-1:0]  shadow [16];
  bit            started = 0;
  bit            m_busy, m_free, m_keep, m_found;
  int            m_ptr, m_age, m_win;
  logic          m_wr;
  logic [AW-1:0] m_addr;
  logic [W-1:0]  m_data;
  logic [N-1:0]  m_tmp, m_tmp2;

  always @(posedge clk) begin
    cyc++;
    started = 1;
    if (rst) begin
      exp_grant = '0; exp_done = '0; exp_we = 0; exp_re = 0;
      exp_ua = '0; exp_ud = '0; exp_rd = '0;
      m_busy = 0; m_ptr = 0; m_age = 0; m_win = 0;
      for (int i = 0; i < 16; i++) shadow[i] = W'(8'h37 + i);
    end else begin
      exp_grant = '0; exp_done = '0; exp_we = 0; exp_re = 0;
      m_free = !m_busy;
      if (m_busy) begin
        if (m_age == 0) begin
          exp_we = m_wr; exp_re = !m_wr; exp_ua = m_addr; exp_ud = m_data;
          if (m_wr) shadow[m_addr] = m_data;
          m_age = 1;
        end else if (m_age == 1) begin
          m_age = 2;
        end else begin
          exp_done = N'(1) << m_win;
          if (!m_wr) exp_rd = shadow[m_addr];
          m_keep = 0;
`ifdef BUFF_UART_ARB_LOCK_EN
          m_tmp  = bus.lock >> m_win;
          m_tmp2 = bus.req >> m_win;
          m_keep = m_tmp[0] && m_tmp2[0];
`endif
          m_ptr  = m_keep ? m_win : (m_win + 1) % N;
          m_busy = 0;
          m_free = 1;
        end
      end
      if (m_free && bus.req != '0) begin
        m_found = 0;
        for (int i = 0; i < N; i++) begin
          m_tmp = bus.req >> ((m_ptr + i) % N);
          if (!m_found && m_tmp[0]) begin
            m_found = 1;
            m_win   = (m_ptr + i) % N;
          end
        end
        exp_grant = N'(1) << m_win;
        m_tmp  = bus.req_write >> m_win;
        m_wr   = m_tmp[0];
        m_addr = AW'(bus.req_address >> (m_win * AW));
        m_data = W'(bus.req_data >> (m_win * W));
        m_busy = 1;
        m_age  = 0;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      chk("grant",   32'(bus.grant),   32'(exp_grant));
      chk("done",    32'(bus.done),    32'(exp_done));
      chk("wr_en",   32'(uwe),         32'(exp_we));
      chk("rd_en",   32'(ure),         32'(exp_re));
      chk("address", 32'(uaddr),       32'(exp_ua));
      chk("data_in", 32'(udin),        32'(exp_ud));
      chk("rd_data", 32'(bus.rd_data), 32'(exp_rd));
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [N-1:0] r, input logic [N-1:0] wr,
                       input logic [N*AW-1:0] a, input logic [N*W-1:0] d);
    bus.req = r; bus.req_write = wr; bus.req_address = a; bus.req_data = d;
  endtask

  // Directed stimulus with hand-computed literal expectations.
  initial begin
    drive('0, '0, '0, '0);
    bus.lock = '0;
    rst = 1'b1;
    repeat (3) tick;
    chk("rst_grant", 32'(bus.grant), 32'h0);
    chk("rst_we",    32'(uwe),       32'h0);
    chk("rst_rd",    32'(bus.rd_data), 32'h0);
    rst = 1'b0;
    tick;
    chk("idle_grant", 32'(bus.grant), 32'h0);

    // Single write: requester 0, addr 3, data A5
    drive(2'b01, 2'b01, 8'h03, 16'h00A5);
    tick; chk("w_grant", 32'(bus.grant), 32'h1);
    drive('0, '0, '0, '0);
    tick; chk("w_we", 32'(uwe), 32'h1); chk("w_re", 32'(ure), 32'h0);
          chk("w_addr", 32'(uaddr), 32'h3); chk("w_din", 32'(udin), 32'hA5);
    tick; chk("w_done_early", 32'(bus.done), 32'h0);
    tick; chk("w_done", 32'(bus.done), 32'h1);

    // Single read: requester 1, addr 5, UART holds 3C
    drive(2'b10, 2'b00, 8'h50, 16'h0000);
    tick; chk("r_grant", 32'(bus.grant), 32'h2);
    drive('0, '0, '0, '0);
    tick; chk("r_re", 32'(ure), 32'h1); chk("r_we", 32'(uwe), 32'h0);
          chk("r_addr", 32'(uaddr), 32'h5);
    tick;
    tick; chk("r_done", 32'(bus.done), 32'h2); chk("r_data", 32'(bus.rd_data), 32'h3C);

    // Simultaneous requests after reset: 01, 10, 01 every 3 cycles
    rst = 1'b1; tick; rst = 1'b0;
    drive(2'b11, 2'b11, 8'h21, 16'h2211);
    tick; chk("rr_g0", 32'(bus.grant), 32'h1);
    tick; chk("rr_gap", 32'(bus.grant), 32'h0);
    tick;
    tick; chk("rr_g1", 32'(bus.grant), 32'h2);
    repeat (3) tick;
    chk("rr_g2", 32'(bus.grant), 32'h1);
    drive('0, '0, '0, '0);
    repeat (4) tick;

    // Reset during ISSUE drops the transfer and clears the pointer
    drive(2'b10, 2'b10, 8'h90, 16'h5A00);
    tick; chk("mr_grant", 32'(bus.grant), 32'h2);
    drive('0, '0, '0, '0);
    tick; chk("mr_issue", 32'(uwe), 32'h1);
    rst = 1'b1;
    tick;
    chk("mr_grant0", 32'(bus.grant), 32'h0); chk("mr_done0", 32'(bus.done), 32'h0);
    chk("mr_we0", 32'(uwe), 32'h0);          chk("mr_re0", 32'(ure), 32'h0);
    chk("mr_addr0", 32'(uaddr), 32'h0);      chk("mr_din0", 32'(udin), 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick; chk("mr_nodone", 32'(bus.done), 32'h0); chk("mr_nowe", 32'(uwe), 32'h0);
    end
    drive(2'b11, 2'b00, 8'h21, 16'h0000);
    tick; chk("mr_ptr0", 32'(bus.grant), 32'h1);
    drive('0, '0, '0, '0);
    repeat (4) tick;

    // Lock: held for two captures, dropped after the third grant
    rst = 1'b1; tick; rst = 1'b0;
    drive(2'b11, 2'b00, 8'h21, 16'h0000);
    bus.lock = 2'b01;
    tick; chk("lk_g0", 32'(bus.grant), 32'h1);
    repeat (3) tick;
`ifdef BUFF_UART_ARB_LOCK_EN
    chk("lk_g1", 32'(bus.grant), 32'h1);
`else
    chk("lk_g1", 32'(bus.grant), 32'h2);
`endif
    repeat (3) tick;
    chk("lk_g2", 32'(bus.grant), 32'h1);
    bus.lock = 2'b00;
    repeat (3) tick;
    chk("lk_g3", 32'(bus.grant), 32'h2);
    drive('0, '0, '0, '0);
    repeat (5) tick;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "time limit");
  end

endmodule
`default_nettype wire
